// File: rtl/loader_pkg.sv
// Shared types and constants for the program loader.
// Optional feature macro: LOADER_CKSUM_EN (adds the trailing checksum byte and S_CKSUM).
package loader_pkg;

    localparam int ADDR_W = 8;
    localparam int WORD_W = 16;

`ifdef LOADER_CKSUM_EN
    typedef enum logic [2:0] {
        S_ADDR,
        S_COUNT,
        S_HI,
        S_LO,
        S_CKSUM,
        S_RUN,
        S_ERR
    } state_t;
`else
    typedef enum logic [2:0] {
        S_ADDR,
        S_COUNT,
        S_HI,
        S_LO,
        S_RUN,
        S_ERR
    } state_t;
`endif

endpackage

// File: rtl/prog_loader.sv
// Program loader: consumes ADDR, COUNT and COUNT 16-bit words (hi byte first)
// from a valid/ready byte stream, writes them to instruction RAM, then releases
// the CPU from reset at the load address.
// Optional feature macro: LOADER_CKSUM_EN (running XOR of data bytes checked
// against one trailing byte; a mismatch parks the loader in S_ERR).
module prog_loader
    import loader_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    input  logic [7:0]          in_data,
    output logic                in_ready,
    input  logic                reload,
    output logic                mem_wren,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [WORD_W-1:0]   mem_wrdata,
    output logic                cpu_rst_n,
    output logic [ADDR_W-1:0]   start_pc,
    output logic                done,
    output logic                err
);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [8:0]          cnt_q, cnt_d;        // words still to load, 1..256
    logic [7:0]          hi_q, hi_d;
    logic [ADDR_W-1:0]   start_pc_q, start_pc_d;
    logic                wren_q, wren_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WORD_W-1:0]   wrdata_q, wrdata_d;
`ifdef LOADER_CKSUM_EN
    logic [7:0]          cksum_q, cksum_d;
`endif
    logic                accept;

    // Streaming states accept bytes; RUN and ERR block the input until reload.
    assign in_ready   = (state_q != S_RUN) && (state_q != S_ERR);
    assign accept     = in_valid && in_ready;
    assign cpu_rst_n  = (state_q == S_RUN);
    assign done       = (state_q == S_RUN);
    assign err        = (state_q == S_ERR);
    assign mem_wren   = wren_q;
    assign mem_addr   = addr_q;
    assign mem_wrdata = wrdata_q;
    assign start_pc   = start_pc_q;

    // Next-state and datapath: reload overrides any byte accepted this cycle.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        start_pc_d = start_pc_q;
        wren_d     = 1'b0;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
`ifdef LOADER_CKSUM_EN
        cksum_d    = cksum_q;
`endif
        if (reload) begin
            state_d = S_ADDR;
`ifdef LOADER_CKSUM_EN
            cksum_d = 8'h00;
`endif
        end else if (accept) begin
            case (state_q)
                S_ADDR: begin
                    start_pc_d = in_data;
                    ptr_d      = in_data;
`ifdef LOADER_CKSUM_EN
                    cksum_d    = 8'h00;
`endif
                    state_d    = S_COUNT;
                end
                S_COUNT: begin
                    cnt_d   = (in_data == 8'h00) ? 9'd256 : {1'b0, in_data};
                    state_d = S_HI;
                end
                S_HI: begin
                    hi_d    = in_data;
`ifdef LOADER_CKSUM_EN
                    cksum_d = cksum_q ^ in_data;
`endif
                    state_d = S_LO;
                end
                S_LO: begin
                    wren_d   = 1'b1;
                    addr_d   = ptr_q;
                    wrdata_d = {hi_q, in_data};
                    ptr_d    = ptr_q + 8'd1;
                    cnt_d    = cnt_q - 9'd1;
`ifdef LOADER_CKSUM_EN
                    cksum_d  = cksum_q ^ in_data;
                    state_d  = (cnt_q == 9'd1) ? S_CKSUM : S_HI;
`else
                    state_d  = (cnt_q == 9'd1) ? S_RUN : S_HI;
`endif
                end
`ifdef LOADER_CKSUM_EN
                S_CKSUM: begin
                    state_d = (in_data == cksum_q) ? S_RUN : S_ERR;
                end
`endif
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // State and datapath registers; reset discards all load progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ADDR;
            ptr_q      <= '0;
            cnt_q      <= '0;
            hi_q       <= '0;
            start_pc_q <= '0;
            wren_q     <= 1'b0;
            addr_q     <= '0;
            wrdata_q   <= '0;
`ifdef LOADER_CKSUM_EN
            cksum_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            start_pc_q <= start_pc_d;
            wren_q     <= wren_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
`ifdef LOADER_CKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: table of load streams with random words,
// checked against a stream-level reference model, plus hand-written sequences
// for reload / reset corner cases. Honours LOADER_CKSUM_EN.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        reload = 1'b0;
    logic        in_ready;
    logic        mem_wren;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wrdata;
    logic        cpu_rst_n;
    logic [7:0]  start_pc;
    logic        done;
    logic        err;

`ifdef LOADER_CKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    always #5 clk = ~clk;

    prog_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .reload     (reload),
        .mem_wren   (mem_wren),
        .mem_addr   (mem_addr),
        .mem_wrdata (mem_wrdata),
        .cpu_rst_n  (cpu_rst_n),
        .start_pc   (start_pc),
        .done       (done),
        .err        (err)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  cap_addr[$];
    logic [15:0] cap_data[$];
    logic [7:0]  exp_addr[$];
    logic [15:0] exp_data[$];
    logic [15:0] words[$];

    // Capture every RAM write strobe; a stretched or doubled pulse shows up as extra entries.
    always @(negedge clk) begin
        if (mem_wren) begin
            cap_addr.push_back(mem_addr);
            cap_data.push_back(mem_wrdata);
        end
    end

    typedef struct {
        logic [7:0] addr;
        logic [7:0] count;
        bit         gap;
        bit         bad;
        int         exp_writes;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int n;
        @(negedge clk);
        if (gap) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic pulse_reload();
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        chk("reload_in_ready", in_ready, 1);
        chk("reload_err", err, 0);
        chk("reload_done", done, 0);
        chk("reload_cpu_rst_n", cpu_rst_n, 0);
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back(16'($urandom));
    endtask

    // Reference model: addresses wrap mod 256, COUNT 0 means 256, checksum is XOR of data bytes.
    task automatic run_load(input logic [7:0] a, input logic [7:0] c, input bit gap,
                            input bit bad, input int exp_writes, input bit exp_done,
                            input bit exp_err);
        int n;
        logic [7:0] ck;
        n = (c == 8'h00) ? 256 : int'(c);
        if (words.size() != n) rand_words(n);
        exp_addr.delete();
        exp_data.delete();
        ck = 8'h00;
        for (int i = 0; i < n; i++) begin
            exp_addr.push_back(8'((int'(a) + i) % 256));
            exp_data.push_back(words[i]);
            ck = ck ^ words[i][15:8] ^ words[i][7:0];
        end
        cap_addr.delete();
        cap_data.delete();
        send_byte(a, gap);
        send_byte(c, gap);
        for (int i = 0; i < n; i++) begin
            send_byte(words[i][15:8], gap);
            send_byte(words[i][7:0], gap);
        end
        if (CK) send_byte(bad ? (ck ^ 8'hA5) : ck, gap);
        @(negedge clk);
        @(negedge clk);
        chk("write_count", cap_addr.size(), exp_writes);
        for (int i = 0; i < exp_addr.size() && i < cap_addr.size(); i++) begin
            chk("wr_addr", cap_addr[i], exp_addr[i]);
            chk("wr_data", cap_data[i], exp_data[i]);
        end
        chk("start_pc", start_pc, a);
        chk("done", done, exp_done);
        chk("err", err, exp_err);
        chk("cpu_rst_n", cpu_rst_n, exp_done);
        chk("in_ready_end", in_ready, !(exp_done || exp_err));
        $display("load addr=%02h count=%02h gap=%0d bad=%0d writes=%0d done=%0d err=%0d ck=%02h",
                 a, c, gap, bad, cap_addr.size(), done, err, ck);
        words.delete();
    endtask

    initial begin
        vecs[0] = '{8'h00, 8'h02, 1'b0, 1'b0, 2,   1'b1, 1'b0};
        vecs[1] = '{8'hFF, 8'h02, 1'b0, 1'b0, 2,   1'b1, 1'b0};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 1'b0, 256, 1'b1, 1'b0};
        vecs[3] = '{8'h37, 8'h05, 1'b1, 1'b0, 5,   1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h03, 1'b1, 1'b1, 3,   !CK,  CK};
        vecs[5] = '{8'hF0, 8'h20, 1'b0, 1'b0, 32,  1'b1, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_mem_wren", mem_wren, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wrdata", mem_wrdata, 0);
        chk("rst_cpu_rst_n", cpu_rst_n, 0);
        chk("rst_start_pc", start_pc, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        $display("reset checked");
        @(negedge clk);
        rst_n = 1'b1;

        // Known-answer stream: D045@00, C100@01 (checksum 54)
        words.delete();
        words.push_back(16'hD045);
        words.push_back(16'hC100);
        run_load(8'h00, 8'h02, 1'b0, 1'b0, 2, 1'b1, 1'b0);
        pulse_reload();

        // Table-driven random loads
        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].addr, vecs[v].count, vecs[v].gap, vecs[v].bad,
                     vecs[v].exp_writes, vecs[v].exp_done, vecs[v].exp_err);
            pulse_reload();
        end

        // Reload after HI byte of word 1, coinciding with a byte transfer
        cap_addr.delete();
        cap_data.delete();
        send_byte(8'h40, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'hAB, 1'b0);
        @(negedge clk);
        reload   = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'hCD;
        @(posedge clk);
        #1;
        reload   = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("partial_reload_writes", cap_addr.size(), 0);
        chk("partial_reload_ready", in_ready, 1);
        $display("partial word dropped by reload, writes=%0d", cap_addr.size());
        run_load(8'h5A, 8'h04, 1'b0, 1'b0, 4, 1'b1, 1'b0);
        pulse_reload();

        // Reload arriving while a write pulse is in flight
        cap_addr.delete();
        cap_data.delete();
        send_byte(8'h10, 1'b0);
        send_byte(8'h03, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        @(negedge clk);
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("inflight_writes", cap_addr.size(), 1);
        if (cap_addr.size() > 0) begin
            chk("inflight_addr", cap_addr[0], 8'h10);
            chk("inflight_data", cap_data[0], 16'h1234);
        end
        chk("inflight_done", done, 0);
        $display("in-flight write kept across reload, writes=%0d", cap_addr.size());

        // Asynchronous reset mid-load after HI byte
        run_load(8'hC0, 8'h01, 1'b0, 1'b0, 1, 1'b1, 1'b0);
        pulse_reload();
        cap_addr.delete();
        cap_data.delete();
        send_byte(8'h20, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h55, 1'b0);
        #2;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_writes", cap_addr.size(), 0);
        chk("midrst_start_pc", start_pc, 0);
        chk("midrst_mem_addr", mem_addr, 0);
        chk("midrst_mem_wrdata", mem_wrdata, 0);
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset mid-load, writes=%0d", cap_addr.size());
        run_load(8'h20, 8'h02, 1'b1, 1'b0, 2, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have `clk`, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have `rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have `in_valid`, input, 1 bit: byte available on in_data.
REQ-004 SHALL have `in_data`, input, 8 bits: load-stream byte.
REQ-005 SHALL have `in_ready`, output, 1 bit: loader accepts a byte; a transfer occurs when in_valid & in_ready are high at a rising edge.
REQ-006 SHALL have `reload`, input, 1 bit: single-cycle request to restart loading.
REQ-007 SHALL have `mem_wren`, output, 1 bit: instruction-RAM write strobe.
REQ-008 SHALL have `mem_addr`, output, 8 bits: RAM word address.
REQ-009 SHALL have `mem_wrdata`, output, 16 bits: instruction word.
REQ-010 SHALL have `cpu_rst_n`, output, 1 bit: active-low reset to the CPU.
REQ-011 SHALL have `start_pc`, output, 8 bits: CPU start address.
REQ-012 SHALL have `done`, output, 1 bit: program loaded and CPU running.
REQ-013 SHALL have `err`, output, 1 bit: load failed.

Function
REQ-014 Stream format SHALL be: ADDR byte, COUNT byte, then COUNT words, each sent high byte first, then low byte.
REQ-015 FSM states SHALL be S_ADDR, S_COUNT, S_HI, S_LO, S_CKSUM, S_RUN and S_ERR.
REQ-016 S_ADDR SHALL latch the accepted byte into start_pc and into the write pointer, then go to S_COUNT.
REQ-017 S_COUNT SHALL latch the word count and go to S_HI; a COUNT of 0 SHALL mean 256 words.
REQ-018 S_HI SHALL hold the accepted byte and go to S_LO.
REQ-019 S_LO, on accepting a byte, SHALL present mem_wrdata = {hi, lo} and mem_addr = pointer, with mem_wren high for exactly the next cycle (registered, latency 1).
REQ-020 After each write, the pointer SHALL increment modulo 256 (0xFF wraps to 0x00).
REQ-021 After each word the FSM SHALL return to S_HI, or, after the last word, go to S_CKSUM (LOADER_CKSUM_EN defined) or S_RUN (not defined).
REQ-022 in_ready SHALL be 1 in S_ADDR, S_COUNT, S_HI, S_LO and S_CKSUM, and 0 in S_RUN and S_ERR.
REQ-023 A byte transfer and an in-flight mem_wren pulse SHALL be able to overlap with no lost bytes.
REQ-024 cpu_rst_n SHALL be 0 in every state except S_RUN; it SHALL rise on the first cycle in S_RUN.
REQ-025 done SHALL be 1 only in S_RUN; err SHALL be 1 only in S_ERR.
REQ-026 reload high in any state SHALL force the next state to S_ADDR, drop cpu_rst_n, clear done/err, and discard any partial word.
REQ-027 If reload and a byte transfer coincide, reload SHALL win and the byte SHALL be dropped.
REQ-028 A write pulse already scheduled when reload arrives SHALL still complete.
REQ-029 in_valid low SHALL stall the FSM indefinitely with no timeout.

Reset
REQ-030 While rst_n = 0 the block SHALL be in S_ADDR with in_ready = 1 (state only; it accepts a byte only once rst_n = 1), mem_wren = 0, mem_addr = 0, mem_wrdata = 0, cpu_rst_n = 0, start_pc = 0, done = 0, err = 0, and pointer, count and checksum = 0.
REQ-031 Reset mid-load SHALL discard all progress; RAM contents already written are not restored.

Configuration
REQ-032 With LOADER_CKSUM_EN defined, the block SHALL keep a running XOR of all data bytes (hi and lo; ADDR and COUNT excluded) and expect one trailing checksum byte in S_CKSUM.
REQ-033 With LOADER_CKSUM_EN defined, a checksum match SHALL go to S_RUN and a mismatch SHALL go to S_ERR, with the CPU held in reset.
REQ-034 Without LOADER_CKSUM_EN, the checksum logic and S_CKSUM SHALL be absent and no trailing byte SHALL be consumed.

Structure
REQ-035 Package loader_pkg SHALL hold the state enum type and the constants ADDR_W = 8 and WORD_W = 16.
REQ-036 The design SHALL be a single module; no sub-module is warranted.

Verification
REQ-037 Stream 00,02,D0,45,C1,00 (plus checksum 54 if enabled) -> writes 0xD045@00, 0xC100@01; start_pc = 00; cpu_rst_n rises and done = 1.
REQ-038 Stream ADDR = FF, COUNT = 02 -> writes land at FF then 00 (wrap).
REQ-039 COUNT = 00 -> exactly 256 writes before S_RUN/S_CKSUM.
REQ-040 in_valid toggling every other cycle mid-word -> identical writes, with no duplicate or missed mem_wren.
REQ-041 (LOADER_CKSUM_EN defined) A wrong checksum byte -> err = 1, cpu_rst_n = 0 and in_ready = 0; a subsequent reload pulse -> S_ADDR with err = 0.
REQ-042 A reload asserted after the HI byte of word 1, or rst_n pulsed low mid-load -> no write for that partial word; a fresh stream then loads correctly.
